// File: rtl/hub75_pkg.sv
`timescale 1ns/1ps
// hub75_pkg: shared widths, bit positions and drain-state type for the
// HUB75 receive path.
package hub75_pkg;

    localparam int RGB_W = 6;
    localparam int PIX_W = 24;

    // LSB of each 4-bit colour field inside a pixel-pair word.
    localparam int R0_LSB = 20;
    localparam int G0_LSB = 16;
    localparam int B0_LSB = 12;
    localparam int R1_LSB = 8;
    localparam int G1_LSB = 4;
    localparam int B1_LSB = 0;

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_t;

    // Bit-plane that follows a latch: consecutive latches on the same row
    // walk planes 0..3, anything else restarts at plane 0.
    function automatic logic [1:0] next_plane(input logic same_row,
                                              input logic [1:0] last);
        if (same_row && last != 2'd3)
            return last + 2'd1;
        return 2'd0;
    endfunction

endpackage

// File: rtl/hub75_plane_demux.sv
`timescale 1ns/1ps
// hub75_plane_demux: places one 6-bit bit-plane sample into its bit of each
// 4-bit colour field; inverse of the driver's bit-plane select.
module hub75_plane_demux
    import hub75_pkg::*;
(
    input  logic [RGB_W-1:0] rgb,
    input  logic [1:0]       plane,
    output logic [PIX_W-1:0] data,
    output logic [PIX_W-1:0] mask
);

    logic [PIX_W-1:0] base_data;
    logic [PIX_W-1:0] base_mask;

    // Build the plane-0 pattern, then shift it up to the selected plane.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned infers a latch.
        base_data = '0;
        base_mask = '0;
        base_data[R0_LSB] = rgb[5];
        base_data[G0_LSB] = rgb[4];
        base_data[B0_LSB] = rgb[3];
        base_data[R1_LSB] = rgb[2];
        base_data[G1_LSB] = rgb[1];
        base_data[B1_LSB] = rgb[0];
        base_mask[R0_LSB] = 1'b1;
        base_mask[G0_LSB] = 1'b1;
        base_mask[B0_LSB] = 1'b1;
        base_mask[R1_LSB] = 1'b1;
        base_mask[G1_LSB] = 1'b1;
        base_mask[B1_LSB] = 1'b1;
        data = base_data << plane;
        mask = base_mask << plane;
    end

endmodule

// File: rtl/hub75_rx.sv
`timescale 1ns/1ps
// hub75_rx: samples the HUB75 bit-plane stream into a double-buffered column
// store and drains each latched row as masked 24-bit pixel-pair writes.
// Define HUB75_RX_SYNC_EN to put 2-flop synchronizers on the panel pins.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int COL_W = 6,
    parameter int ROW_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   panel_clk,
    input  logic                   panel_lat,
    input  logic [ROW_W-1:0]       panel_addr,
    input  logic [5:0]             panel_rgb,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ROW_W+COL_W-1:0] wr_addr,
    output logic [23:0]            wr_data,
    output logic [23:0]            wr_mask,
    output logic [1:0]             plane,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int COLS = 2 ** COL_W;
    localparam int IN_W = 2 + ROW_W + RGB_W;

    logic [IN_W-1:0]  pins;
    logic [IN_W-1:0]  pins_s;
    logic [IN_W-1:0]  in_q;
    logic             clk_q2;
    logic             lat_q2;
    logic             shift_rise;
    logic             lat_rise;
    logic [ROW_W-1:0] q_addr;
    logic [RGB_W-1:0] q_rgb;

    drain_state_t     state;
    logic             bank;
    logic [COL_W:0]   col_cnt;
    logic             col_full;
    logic [COL_W-1:0] dcol;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] last_row;
    logic [1:0]       last_plane;
    logic [1:0]       nxt_plane;

    logic [RGB_W-1:0] mem [2][COLS];
    logic [RGB_W-1:0] rd_rgb;
    logic [PIX_W-1:0] dm_data;
    logic [PIX_W-1:0] dm_mask;

    assign pins = {panel_clk, panel_lat, panel_addr, panel_rgb};

`ifdef HUB75_RX_SYNC_EN
    logic [IN_W-1:0] sync_a;
    logic [IN_W-1:0] sync_b;

    // Two-flop synchronizer on every panel pin; addr/rgb are stable around
    // the shift and latch edges, so bitwise synchronization is safe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= pins;
            sync_b <= sync_a;
        end
    end

    assign pins_s = sync_b;
`else
    assign pins_s = pins;
`endif

    // Edge-detect stage: register the pins, then keep one older copy of
    // panel_clk and panel_lat to find their rising edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q   <= '0;
            clk_q2 <= 1'b0;
            lat_q2 <= 1'b0;
        end else begin
            in_q   <= pins_s;
            clk_q2 <= in_q[IN_W-1];
            lat_q2 <= in_q[IN_W-2];
        end
    end

    assign shift_rise = in_q[IN_W-1] & ~clk_q2;
    assign lat_rise   = in_q[IN_W-2] & ~lat_q2;
    assign q_addr     = in_q[RGB_W +: ROW_W];
    assign q_rgb      = in_q[RGB_W-1:0];
    assign col_full   = col_cnt[COL_W];
    assign nxt_plane  = next_plane(q_addr == last_row, last_plane);

    // Column store write port: shifts land in the active bank.
    always_ff @(posedge clk) begin
        // NOTE: the column store has no reset; every column is rewritten
        // before it is drained, and a reset port would block RAM inference.
        if (shift_rise && !col_full)
            mem[bank][col_cnt[COL_W-1:0]] <= q_rgb;
    end

    // Column counting, bank swap on latch, and the drain FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bank       <= 1'b0;
            col_cnt    <= '0;
            dcol       <= '0;
            row        <= '0;
            last_row   <= '0;
            last_plane <= 2'd3;
            plane      <= 2'd0;
            wr_valid   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (shift_rise) begin
                if (col_full)
                    overrun <= 1'b1;
                else
                    col_cnt <= col_cnt + 1'b1;
            end

            // A latch always restarts column counting; being later, this
            // clear wins over a same-cycle increment.
            if (lat_rise)
                col_cnt <= '0;

            case (state)
                IDLE: begin
                    if (lat_rise) begin
                        row        <= q_addr;
                        plane      <= nxt_plane;
                        last_row   <= q_addr;
                        last_plane <= nxt_plane;
                        bank       <= ~bank;
                        dcol       <= '0;
                        wr_valid   <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (lat_rise)
                        overrun <= 1'b1;
                    if (wr_ready) begin
                        if (&dcol) begin
                            wr_valid   <= 1'b0;
                            frame_done <= (&row) && (plane == 2'd3);
                            state      <= IDLE;
                        end else begin
                            dcol <= dcol + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The drained bank is never written during DRAIN, so the beat read from
    // it stays stable while the RAM stalls.
    assign rd_rgb = mem[~bank][dcol];

    hub75_plane_demux u_demux (
        .rgb   (rd_rgb),
        .plane (plane),
        .data  (dm_data),
        .mask  (dm_mask)
    );

    assign wr_addr = {row, dcol};
    assign wr_data = dm_data & {PIX_W{wr_valid}};
    assign wr_mask = dm_mask & {PIX_W{wr_valid}};

endmodule

// File: tb/tb_hub75_rx.sv
`timescale 1ns/1ps
// tb_hub75_rx: randomized self-checking bench for hub75_rx against a
// line/bank-level reference model.
module tb_hub75_rx;

    localparam int COL_W = 6;
    localparam int ROW_W = 5;
    localparam int COLS  = 64;
`ifdef HUB75_RX_SYNC_EN
    localparam int PH   = 3;
    localparam int LAT0 = 5;
`else
    localparam int PH   = 2;
    localparam int LAT0 = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        panel_clk;
    logic        panel_lat;
    logic [4:0]  panel_addr;
    logic [5:0]  panel_rgb;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [23:0] wr_data;
    logic [23:0] wr_mask;
    logic [1:0]  plane;
    logic        frame_done;
    logic        overrun;

    hub75_rx #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_addr (panel_addr),
        .panel_rgb  (panel_rgb),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .plane      (plane),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [23:0] data;
        logic [23:0] mask;
        logic [1:0]  plane;
    } beat_t;

    beat_t beats[$];
    beat_t last_beat;
    int    cyc;
    int    fd_count;
    int    fd_cyc;
    int    last_xfer_cyc;
    int    n_tests;
    int    n_fail;

    // Reference model: two banks of columns, active bank, fill count,
    // latch history and sticky overrun.
    logic [5:0] m_bank [2][COLS];
    int         m_act;
    int         m_cnt;
    int         m_last_row;
    int         m_last_plane;
    bit         m_ovr;
    logic [5:0] exp_line [COLS];
    int         exp_plane;
    int         exp_row;

    // Beat and frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (wr_valid && wr_ready) begin
            beats.push_back('{addr: wr_addr, data: wr_data, mask: wr_mask, plane: plane});
            last_xfer_cyc = cyc;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
    end

    // Place bit k of a plane sample at field bit 4*k + p.
    function automatic logic [23:0] spread(input logic [5:0] rgb, input int p);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < 6; k++)
            if (rgb[k]) v = v | (24'd1 << (4 * k + p));
        return v;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        panel_clk  = 1'b0;
        panel_lat  = 1'b0;
        panel_addr = '0;
        panel_rgb  = '0;
        wr_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        m_act = 0; m_cnt = 0; m_last_row = 0; m_last_plane = 3; m_ovr = 0;
        @(posedge clk); #1;
        beats.delete();
    endtask

    task automatic shift(input logic [5:0] rgb);
        panel_rgb = rgb;
        panel_clk = 1'b1;
        repeat (PH) @(posedge clk);
        #1 panel_clk = 1'b0;
        repeat (PH) @(posedge clk);
        #1;
        if (m_cnt < COLS) begin
            m_bank[m_act][m_cnt] = rgb;
            m_cnt++;
        end else begin
            m_ovr = 1;
        end
    endtask

    task automatic shift_random(input int n);
        for (int i = 0; i < n; i++) shift(6'($urandom_range(0, 63)));
    endtask

    task automatic model_latch(input int r, input bit during_drain);
        if (during_drain) begin
            m_ovr = 1;
            m_cnt = 0;
        end else begin
            exp_plane = (r == m_last_row && m_last_plane != 3) ? m_last_plane + 1 : 0;
            exp_row   = r;
            for (int c = 0; c < COLS; c++) exp_line[c] = m_bank[m_act][c];
            m_act        = 1 - m_act;
            m_cnt        = 0;
            m_last_row   = r;
            m_last_plane = exp_plane;
        end
    endtask

    task automatic drive_latch(input int r);
        panel_addr = 5'(r);
        panel_lat  = 1'b1;
        repeat (PH) @(posedge clk);
        #1 panel_lat = 1'b0;
        repeat (PH) @(posedge clk);
        #1;
    endtask

    task automatic collect(input bit rnd_ready, input string name);
        int t;
        beat_t b;
        logic [10:0] ea;
        t = 0;
        while (beats.size() < COLS && t < 3000) begin
            @(posedge clk); #1;
            if (rnd_ready) wr_ready = ($urandom_range(0, 3) != 0);
            t++;
        end
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (beats.size() != COLS) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d want %0d", name, beats.size(), COLS);
            beats.delete();
            return;
        end
        for (int c = 0; c < COLS; c++) begin
            b  = beats.pop_front();
            ea = {5'(exp_row), 6'(c)};
            n_tests++;
            if (b.addr !== ea || b.plane !== 2'(exp_plane) ||
                b.data !== spread(exp_line[c], exp_plane) ||
                b.mask !== spread(6'h3f, exp_plane)) begin
                n_fail++;
                $display("FAIL %s beat%0d: got addr=%h plane=%0d data=%h mask=%h want addr=%h plane=%0d data=%h mask=%h",
                         name, c, b.addr, b.plane, b.data, b.mask, ea, exp_plane,
                         spread(exp_line[c], exp_plane), spread(6'h3f, exp_plane));
            end
            last_beat = b;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({wr_valid, frame_done, overrun, plane} !== 5'b0 || wr_addr !== 11'd0 ||
            wr_data !== 24'd0 || wr_mask !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b fd=%b ovr=%b plane=%0d addr=%h data=%h mask=%h want all 0",
                     wr_valid, frame_done, overrun, plane, wr_addr, wr_data, wr_mask);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_plane();
        int k;
        do_reset();
        for (int i = 0; i < COLS; i++) shift(6'b101010);
        model_latch(3, 0);
        panel_addr = 5'd3;
        panel_lat  = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (wr_valid) break;
        end
        n_tests++;
        if (k != LAT0) begin
            n_fail++;
            $display("FAIL latch_to_valid: got %0d cycles want %0d", k, LAT0);
        end
        @(posedge clk); #1;
        panel_lat = 1'b0;
        collect(0, "single_plane");
        n_tests++;
        if (last_beat.data !== 24'h101010 || last_beat.mask !== 24'h111111 ||
            last_beat.addr !== {5'd3, 6'd63}) begin
            n_fail++;
            $display("FAIL single_plane_word: got addr=%h data=%h mask=%h want addr=0ff data=101010 mask=111111",
                     last_beat.addr, last_beat.data, last_beat.mask);
        end
    endtask

    task automatic test_plane_sequence();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                for (int c = 0; c < COLS; c++) shift(6'h3f);
            end else begin
                shift_random(COLS);
            end
            model_latch(3, 0);
            drive_latch(3);
            collect(1, "plane_seq");
        end
        n_tests++;
        if (last_beat.data !== 24'h888888 || last_beat.mask !== 24'h888888 || last_beat.plane !== 2'd3) begin
            n_fail++;
            $display("FAIL plane3_word: got plane=%0d data=%h mask=%h want plane=3 data=888888 mask=888888",
                     last_beat.plane, last_beat.data, last_beat.mask);
        end
        shift_random(COLS);
        model_latch(4, 0);
        drive_latch(4);
        collect(1, "new_row");
        n_tests++;
        if (last_beat.plane !== 2'd0) begin
            n_fail++;
            $display("FAIL new_row_plane: got %0d want 0", last_beat.plane);
        end
    endtask

    task automatic test_backpressure();
        int t;
        logic [10:0] sa;
        logic [23:0] sd;
        logic [23:0] sm;
        logic [1:0]  sp;
        do_reset();
        shift_random(COLS);
        model_latch(7, 0);
        drive_latch(7);
        t = 0;
        while (!(wr_valid && wr_addr[5:0] == 6'd9) && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        wr_ready = 1'b0;
        @(negedge clk);
        sa = wr_addr; sd = wr_data; sm = wr_mask; sp = plane;
        n_tests++;
        if (!wr_valid || sa !== {5'd7, 6'd10}) begin
            n_fail++;
            $display("FAIL stall_beat: got valid=%b addr=%h want valid=1 addr=%h", wr_valid, sa, {5'd7, 6'd10});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (!wr_valid || wr_addr !== sa || wr_data !== sd || wr_mask !== sm || plane !== sp) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b addr=%h data=%h mask=%h want addr=%h data=%h mask=%h",
                         i, wr_valid, wr_addr, wr_data, wr_mask, sa, sd, sm);
            end
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        collect(0, "backpressure");
    endtask

    task automatic test_frame_end();
        int fd0;
        do_reset();
        fd0 = fd_count;
        for (int r = 0; r < 32; r++) begin
            for (int p = 0; p < 4; p++) begin
                if (r == 31 && p == 3) begin
                    n_tests++;
                    if (fd_count != fd0) begin
                        n_fail++;
                        $display("FAIL early_frame_done: got %0d pulses want 0", fd_count - fd0);
                    end
                end
                shift_random(COLS);
                model_latch(r, 0);
                drive_latch(r);
                collect(1, "frame");
            end
        end
        n_tests++;
        if (fd_count - fd0 != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d want 1", fd_count - fd0);
        end
        n_tests++;
        if (fd_cyc != last_xfer_cyc + 1) begin
            n_fail++;
            $display("FAIL frame_done_timing: got cycle %0d want %0d", fd_cyc, last_xfer_cyc + 1);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        shift_random(COLS);
        n_tests++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun_64: got %b want %b", overrun, m_ovr);
        end
        shift_random(1);
        n_tests++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun_65: got %b want %b", overrun, m_ovr);
        end
        model_latch(10, 0);
        drive_latch(10);
        collect(1, "overrun_line");

        do_reset();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_cleared: got %b want 0", overrun);
        end
        shift_random(COLS);
        wr_ready = 1'b0;
        model_latch(9, 0);
        drive_latch(9);
        n_tests++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun_before_relatch: got %b want %b", overrun, m_ovr);
        end
        model_latch(12, 1);
        drive_latch(12);
        n_tests++;
        if (overrun !== m_ovr || !wr_valid || wr_addr !== {5'd9, 6'd0}) begin
            n_fail++;
            $display("FAIL latch_in_drain: got ovr=%b valid=%b addr=%h want ovr=%b valid=1 addr=%h",
                     overrun, wr_valid, wr_addr, m_ovr, {5'd9, 6'd0});
        end
        wr_ready = 1'b1;
        collect(0, "drain_after_relatch");
    endtask

    task automatic test_reset_mid_drain();
        int t;
        int fd0;
        do_reset();
        fd0 = fd_count;
        shift_random(COLS);
        model_latch(5, 0);
        drive_latch(5);
        t = 0;
        while (!(wr_valid && wr_addr[5:0] == 6'd20) && t < 300) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drain_valid: got %b want 0", wr_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_act = 0; m_cnt = 0; m_last_row = 0; m_last_plane = 3; m_ovr = 0;
        repeat (3) @(posedge clk);
        #1;
        beats.delete();
        n_tests++;
        if (fd_count != fd0) begin
            n_fail++;
            $display("FAIL mid_drain_frame_done: got %0d pulses want 0", fd_count - fd0);
        end
        shift_random(COLS);
        model_latch(5, 0);
        drive_latch(5);
        collect(1, "after_reset");
        n_tests++;
        if (last_beat.plane !== 2'd0) begin
            n_fail++;
            $display("FAIL after_reset_plane: got %0d want 0", last_beat.plane);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < COLS; c++) m_bank[b][c] = '0;
        test_reset();
        test_single_plane();
        test_plane_sequence();
        test_backpressure();
        test_overrun();
        test_reset_mid_drain();
        test_frame_end();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
